// File: rtl/arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package arb_pkg;

  // Owner of the data-memory port.
  typedef enum logic {
    ARB_CPU   = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int unsigned BURST_LEN_DEFAULT  = 8;
  localparam int unsigned CAM_STARVE_DEFAULT = 4;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  // Wide enough for the largest starvation threshold (15).
  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/burst_addr_gen.sv
// Camera burst address generator: latches the word-aligned base, counts beats
// and flags the final beat of the burst.
module burst_addr_gen
  import arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] cam_addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int unsigned          BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0]    ALIGN_MSK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  // Load base on burst entry, otherwise step the beat while the burst runs.
  always_comb begin
    base_d = base_q;
    beat_d = beat_q;
    if (start_i) begin
      base_d = cam_addr_i & ALIGN_MSK;
      beat_d = '0;
    end else if (adv_i) begin
      beat_d = last_o ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // Base and beat registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= '0;
      beat_q <= '0;
    end else begin
      base_q <= base_d;
      beat_q <= beat_d;
    end
  end

  // Word address of the current beat; wraps modulo 2^32.
  assign addr_o = base_q + ADDR_W'({beat_q, 2'b00});
  assign last_o = (beat_q == LAST_BEAT);

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory port arbiter between the CPU memory stage and a camera FIFO
// that writes fixed-length, non-preemptible bursts.
module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned BURST_LEN  = BURST_LEN_DEFAULT,
  parameter int unsigned CAM_STARVE = CAM_STARVE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cam_req,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_wdata,
  output logic              cam_pop,
  output logic              cam_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(CAM_STARVE);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                burst_start;
  logic                burst_adv;
  logic                burst_last;
  logic [ADDR_W-1:0]   burst_addr;

  burst_addr_gen #(
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .start_i    (burst_start),
    .adv_i      (burst_adv),
    .cam_addr_i (cam_addr),
    .addr_o     (burst_addr),
    .last_o     (burst_last)
  );

  // Next-state, starvation counting and port muxing.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    burst_start = 1'b0;
    burst_adv   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = cpu_addr;
    mem_wdata   = cpu_wdata;
    cpu_stall   = 1'b0;
    cam_pop     = 1'b0;
    cam_done    = 1'b0;

    case (state_q)
      ARB_CPU: begin
        mem_we = cpu_req & cpu_we;
        if (cam_req && cpu_req && (starve_q != STARVE_MAX)) begin
          starve_d = starve_q + STARVE_W'(1);
        end
        // The CPU access of this cycle still completes; the camera takes the
        // port from the next edge on.
        if (cam_req && (!cpu_req || (starve_q == STARVE_MAX))) begin
          state_d     = ARB_BURST;
          burst_start = 1'b1;
          starve_d    = '0;
        end
      end
      ARB_BURST: begin
        burst_adv = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = burst_addr;
        mem_wdata = cam_wdata;
        cam_pop   = 1'b1;
        cpu_stall = cpu_req;
        if (burst_last) begin
          cam_done = 1'b1;
          state_d  = ARB_CPU;
        end
      end
      default: begin
        state_d = ARB_CPU;
      end
    endcase

    // Control outputs are forced quiet while reset is held.
    if (!reset) begin
      mem_we    = 1'b0;
      cpu_stall = 1'b0;
      cam_pop   = 1'b0;
      cam_done  = 1'b0;
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_CPU;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a cycle-level ownership model.
module tb_data_mem_arbiter;

  localparam int unsigned BL = 8;
  localparam int unsigned CS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        cam_req;
  logic [31:0] cam_addr, cam_wdata;
  logic        cam_pop, cam_done;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [1024];
  logic [31:0] cam_words [256];
  logic [7:0]  word_idx;
  logic        mem_clear;
  logic        pop_seen = 1'b0;
  logic        wr_pend  = 1'b0;
  logic [31:0] wr_addr  = '0;
  logic [31:0] wr_data  = '0;
  logic [31:0] wrap_addr [8];

  int errors = 0;
  int checks = 0;

  // Model of port ownership: m_left = remaining burst beats (0 = CPU owns).
  int          m_left = 0;
  int          m_wait = 0;
  int          m_beat = 0;
  logic [31:0] m_base = '0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .BURST_LEN  (BL),
    .CAM_STARVE (CS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cam_req   (cam_req),
    .cam_addr  (cam_addr),
    .cam_wdata (cam_wdata),
    .cam_pop   (cam_pop),
    .cam_done  (cam_done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];
  assign cam_wdata = cam_words[word_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_fifo(input logic [31:0] first);
    for (int k = 0; k < 32; k++) cam_words[8'(int'(word_idx) + k)] = first + 32'(k);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory and FIFO side effects, using values captured at the previous negedge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      word_idx <= '0;
    end else begin
      if (wr_pend) mem[wr_addr[11:2]] <= wr_data;
      if (pop_seen) word_idx <= word_idx + 8'd1;
    end
  end

  // Every-cycle comparison against the ownership model.
  always @(negedge clk) begin
    pop_seen = 1'b0;
    wr_pend  = 1'b0;
    if (!reset) begin
      chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("rst_cam_pop",   32'(cam_pop),   32'd0);
      chk("rst_cam_done",  32'(cam_done),  32'd0);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
      m_left = 0;
      m_wait = 0;
      m_beat = 0;
      m_base = '0;
    end else begin
      wr_pend  = mem_we;
      wr_addr  = mem_addr;
      wr_data  = mem_wdata;
      pop_seen = cam_pop;
      if (m_left == 0) begin
        chk("cpu_mem_we",    32'(mem_we),    32'(cpu_req & cpu_we));
        chk("cpu_mem_addr",  mem_addr,       cpu_addr);
        chk("cpu_mem_wdata", mem_wdata,      cpu_wdata);
        chk("cpu_stall",     32'(cpu_stall), 32'd0);
        chk("cpu_cam_pop",   32'(cam_pop),   32'd0);
        chk("cpu_cam_done",  32'(cam_done),  32'd0);
        if (cpu_req) chk("cpu_rdata", cpu_rdata, mem[cpu_addr[11:2]]);
        if (cam_req && (!cpu_req || m_wait == int'(CS))) begin
          m_left = int'(BL);
          m_beat = 0;
          m_wait = 0;
          m_base = {cam_addr[31:2], 2'b00};
        end else if (cam_req && cpu_req && m_wait < int'(CS)) begin
          m_wait++;
        end
      end else begin
        chk("bur_mem_we",    32'(mem_we),    32'd1);
        chk("bur_mem_addr",  mem_addr,       m_base + 32'(4 * m_beat));
        chk("bur_mem_wdata", mem_wdata,      cam_wdata);
        chk("bur_cam_pop",   32'(cam_pop),   32'd1);
        chk("bur_cpu_stall", 32'(cpu_stall), 32'(cpu_req));
        chk("bur_cam_done",  32'(cam_done),  32'(m_left == 1));
        m_beat++;
        m_left--;
      end
    end
  end

  initial begin
    int served, dones, first_stall, writes;
    reset = 1'b0; mem_clear = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cam_req = 1'b0; cam_addr = '0;
    for (int i = 0; i < 256; i++) cam_words[i] = '0;
    wrap_addr[0] = 32'hFFFF_FFF4; wrap_addr[1] = 32'hFFFF_FFF8;
    wrap_addr[2] = 32'hFFFF_FFFC; wrap_addr[3] = 32'h0000_0000;
    wrap_addr[4] = 32'h0000_0004; wrap_addr[5] = 32'h0000_0008;
    wrap_addr[6] = 32'h0000_000C; wrap_addr[7] = 32'h0000_0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_cam_pop", 32'(cam_pop), 32'd0);
    chk("init_mem_we",  32'(mem_we),  32'd0);
    next_cycle();
    reset = 1'b1; mem_clear = 1'b0;

    // 1: idle CPU, 8-word burst at 0x100 with data 1..8.
    load_fifo(32'd1);
    cam_req = 1'b1; cam_addr = 32'h100;
    @(negedge clk);
    chk("s1_req_cycle_pop", 32'(cam_pop), 32'd0);
    next_cycle();
    cam_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s1_addr",  mem_addr,        32'h100 + 32'(4 * k));
      chk("s1_data",  mem_wdata,       32'(k + 1));
      chk("s1_done",  32'(cam_done),   32'(k == 7));
      chk("s1_stall", 32'(cpu_stall),  32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("s1_after_pop", 32'(cam_pop), 32'd0);
    next_cycle();

    // 2: contended load from 0x40; counter 0..4 gives five served cycles.
    load_fifo(32'h200);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cam_req = 1'b1; cam_addr = 32'h300;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s2_served", 32'(cpu_stall), 32'd0);
      chk("s2_rdata",  cpu_rdata,      32'hA000_0010);
      next_cycle();
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s2_stalled", 32'(cpu_stall), 32'd1);
      next_cycle();
      cam_req = 1'b0;
    end
    @(negedge clk);
    chk("s2_resume",       32'(cpu_stall), 32'd0);
    chk("s2_resume_rdata", cpu_rdata,      32'hA000_0010);
    next_cycle();
    cpu_req = 1'b0;

    // 3: unaligned base near the top of the address space wraps to 0.
    load_fifo(32'h300);
    cam_req = 1'b1; cam_addr = 32'hFFFF_FFF6;
    @(negedge clk);
    next_cycle();
    cam_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s3_wrap_addr", mem_addr, wrap_addr[k]);
      next_cycle();
    end

    // 4: reset at beat 3 aborts the burst, earlier words stay written.
    load_fifo(32'h400);
    cam_req = 1'b1; cam_addr = 32'h500;
    @(negedge clk);
    next_cycle();
    cam_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s4_addr", mem_addr, 32'h500 + 32'(4 * k));
      next_cycle();
    end
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h90;
    #1;
    chk("s4_async_pop",   32'(cam_pop),   32'd0);
    chk("s4_async_we",    32'(mem_we),    32'd0);
    chk("s4_async_done",  32'(cam_done),  32'd0);
    chk("s4_async_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    chk("s4_post_pop",   32'(cam_pop),   32'd0);
    chk("s4_post_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h1234;
    @(negedge clk);
    chk("s4_cpu_we",   32'(mem_we), 32'd1);
    chk("s4_cpu_addr", mem_addr,    32'h80);
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("s4_mem_b0",   mem[10'h140], 32'h400);
    chk("s4_mem_b1",   mem[10'h141], 32'h401);
    chk("s4_mem_b2",   mem[10'h142], 32'h402);
    chk("s4_mem_b3",   mem[10'h143], 32'hA000_0143);
    chk("s4_mem_cpu",  mem[10'h020], 32'h1234);

    // 5: both requesters held: 5 served + 8 stalled, repeated three times.
    load_fifo(32'h500);
    cpu_req = 1'b1; cpu_addr = 32'h44; cam_req = 1'b1; cam_addr = 32'h600;
    served = 0; dones = 0; first_stall = -1;
    for (int c = 0; c < 39; c++) begin
      @(negedge clk);
      if (!cpu_stall) served++;
      if (cam_done) dones++;
      if (cpu_stall && first_stall < 0) first_stall = c;
      next_cycle();
    end
    cam_req = 1'b0; cpu_req = 1'b0;
    chk("s5_served",      32'(served),      32'd15);
    chk("s5_dones",       32'(dones),       32'd3);
    chk("s5_first_stall", 32'(first_stall), 32'd5);

    // 6: cam_req drops at beat 2; the burst still completes.
    load_fifo(32'h600);
    cam_req = 1'b1; cam_addr = 32'h700;
    @(negedge clk);
    next_cycle();
    writes = 0; dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) cam_req = 1'b0;
      @(negedge clk);
      if (mem_we && cam_pop) writes++;
      if (cam_done) dones++;
      next_cycle();
    end
    chk("s6_writes", 32'(writes), 32'd8);
    chk("s6_dones",  32'(dones),  32'd1);
    @(negedge clk);
    chk("s6_after_we", 32'(mem_we), 32'd0);
    next_cycle();
    chk("s6_last_word", mem[10'h1C7], 32'h607);

    repeat (2) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
